// File: rtl/pe_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// pe_scheduler_pkg
// Shared types and constants for the PE job sequencer: default parameter
// values, configuration field widths, the sequencer state encoding and the
// latched job configuration record.
// -----------------------------------------------------------------------------
package pe_scheduler_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_INST_WIDTH = 32;
    localparam int DEF_REG_NUM    = 8;
    localparam int DEF_DRAIN_MAX  = 64;

    // Widths of the job configuration fields and of the run-phase counters.
    localparam int N_INST_W = 6;
    localparam int CNT_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LD_INST = 3'd1,
        ST_LD_DATA = 3'd2,
        ST_RUN     = 3'd3,
        ST_DRAIN   = 3'd4
    } state_e;

    // Job configuration captured when a start is accepted.
    typedef struct packed {
        logic [N_INST_W-1:0] n_inst;
        logic [CNT_W-1:0]    n_iter;
        logic [CNT_W-1:0]    iter_len;
    } job_cfg_t;

    // An iteration length of zero behaves as a single-cycle iteration.
    function automatic logic [CNT_W-1:0] eff_iter_len(input logic [CNT_W-1:0] len);
        return (len == '0) ? CNT_W'(1) : len;
    endfunction

endpackage

// File: rtl/pe_scheduler_stream_reg.sv
// -----------------------------------------------------------------------------
// pe_scheduler_stream_reg
// One-entry valid/data pipeline register used on both host-to-PE forwarding
// paths. The valid bit follows the input every cycle; the data word is only
// captured when the input is valid and holds otherwise.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   in_v_i     : accepted-word strobe (host handshake)
//   in_data_i  : word to forward
//   out_v_o    : registered valid towards the PE
//   out_data_o : registered word towards the PE
// -----------------------------------------------------------------------------
module pe_scheduler_stream_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_v_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_v_o,
    output logic [WIDTH-1:0] out_data_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // NOTE: the data register is reset as well as the valid bit, so the PE
    // never sees a stale word on its data port after a reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= in_v_i;
            if (in_v_i) begin
                data_q <= in_data_i;
            end
        end
    end

    assign out_v_o    = valid_q;
    assign out_data_o = data_q;

endmodule

// File: rtl/pe_scheduler.sv
// -----------------------------------------------------------------------------
// pe_scheduler
// Drives one PE through a complete job: loads a program and an operand burst
// from the host, times the iteration loop (flagging the final iteration on
// alpha_v), then waits a bounded time for the PE result and reports done.
//
// Ports:
//   clk, rst                      : clock; asynchronous active-high reset
//   start                         : job request, only honoured in IDLE
//   cfg_n_inst/n_iter/iter_len    : job configuration, latched on start
//   host_inst_v/host_inst/_rdy    : instruction stream from the host
//   host_data_v/host_data/_rdy    : operand stream from the host
//   inst_in_v/inst_in             : registered instruction stream to the PE
//   din_pe_v/din_pe               : registered operand stream to the PE
//   alpha_v                       : high for the whole final iteration
//   dout_pe_v                     : PE result valid, honoured only in DRAIN
//   busy/done/err_timeout         : job status (done is a 1-cycle pulse)
// -----------------------------------------------------------------------------
module pe_scheduler
    import pe_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int INST_WIDTH = DEF_INST_WIDTH,
    parameter int REG_NUM    = DEF_REG_NUM,
    parameter int DRAIN_MAX  = DEF_DRAIN_MAX
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [N_INST_W-1:0]     cfg_n_inst,
    input  logic [CNT_W-1:0]        cfg_n_iter,
    input  logic [CNT_W-1:0]        cfg_iter_len,
    input  logic                    host_inst_v,
    input  logic [INST_WIDTH-1:0]   host_inst,
    output logic                    host_inst_rdy,
    input  logic                    host_data_v,
    input  logic [2*DATA_WIDTH-1:0] host_data,
    output logic                    host_data_rdy,
    output logic                    inst_in_v,
    output logic [INST_WIDTH-1:0]   inst_in,
    output logic                    din_pe_v,
    output logic [2*DATA_WIDTH-1:0] din_pe,
    output logic                    alpha_v,
    input  logic                    dout_pe_v,
    output logic                    busy,
    output logic                    done,
    output logic                    err_timeout
);

    localparam int DATA_WORDS = 2 * REG_NUM;
    localparam int DCNT_W     = $clog2(DATA_WORDS + 1);
    localparam int DRAIN_W    = $clog2(DRAIN_MAX + 1);

    localparam logic [DCNT_W-1:0]  DATA_LAST  = DCNT_W'(DATA_WORDS - 1);
    localparam logic [DCNT_W-1:0]  DATA_ALL   = DCNT_W'(DATA_WORDS);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_MAX - 1);

    state_e              state_q,     state_d;
    job_cfg_t            cfg_q,       cfg_d;
    logic [N_INST_W-1:0] inst_cnt_q,  inst_cnt_d;
    logic [DCNT_W-1:0]   data_cnt_q,  data_cnt_d;
    logic [CNT_W-1:0]    cyc_cnt_q,   cyc_cnt_d;
    logic [CNT_W-1:0]    iter_cnt_q,  iter_cnt_d;
    logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic                inst_rdy_q,  inst_rdy_d;
    logic                data_rdy_q,  data_rdy_d;
    logic                done_q,      done_d;
    logic                err_q,       err_d;

    logic inst_hs;
    logic data_hs;
    logic last_cyc;
    logic last_iter;

    assign inst_hs   = host_inst_v & inst_rdy_q;
    assign data_hs   = host_data_v & data_rdy_q;
    assign last_cyc  = (cyc_cnt_q == cfg_q.iter_len - CNT_W'(1));
    assign last_iter = (iter_cnt_q == cfg_q.n_iter - CNT_W'(1));

    // NOTE: sequential state is updated only with <= so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cfg_q       <= '0;
            inst_cnt_q  <= '0;
            data_cnt_q  <= '0;
            cyc_cnt_q   <= '0;
            iter_cnt_q  <= '0;
            drain_cnt_q <= '0;
            inst_rdy_q  <= 1'b0;
            data_rdy_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            inst_cnt_q  <= inst_cnt_d;
            data_cnt_q  <= data_cnt_d;
            cyc_cnt_q   <= cyc_cnt_d;
            iter_cnt_q  <= iter_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            inst_rdy_q  <= inst_rdy_d;
            data_rdy_q  <= data_rdy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // NOTE: every next-state variable gets its hold value first, so no
    // branch below can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        inst_cnt_d  = inst_cnt_q;
        data_cnt_d  = data_cnt_q;
        cyc_cnt_d   = cyc_cnt_q;
        iter_cnt_d  = iter_cnt_q;
        drain_cnt_d = drain_cnt_q;
        done_d      = 1'b0;
        err_d       = err_q;

        unique case (state_q)
            ST_IDLE: begin
                // A start coinciding with the done pulse is dropped.
                if (start && !done_q) begin
                    cfg_d.n_inst   = cfg_n_inst;
                    cfg_d.n_iter   = cfg_n_iter;
                    cfg_d.iter_len = eff_iter_len(cfg_iter_len);
                    err_d          = 1'b0;
                    inst_cnt_d     = '0;
                    data_cnt_d     = '0;
                    cyc_cnt_d      = '0;
                    iter_cnt_d     = '0;
                    drain_cnt_d    = '0;
                    state_d        = (cfg_n_inst != '0) ? ST_LD_INST : ST_LD_DATA;
                end
            end

            ST_LD_INST: begin
                if (inst_hs) begin
                    inst_cnt_d = inst_cnt_q + N_INST_W'(1);
                    if (inst_cnt_d == cfg_q.n_inst) begin
                        state_d = ST_LD_DATA;
                    end
                end
            end

            ST_LD_DATA: begin
                // Once the burst is complete, one extra cycle lets the final
                // word reach the PE before the run phase begins.
                if (data_cnt_q == DATA_ALL) begin
                    state_d = ST_RUN;
                end else if (data_hs) begin
                    data_cnt_d = data_cnt_q + DCNT_W'(1);
                    if (data_cnt_q == DATA_LAST && cfg_q.n_iter == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                if (last_cyc) begin
                    cyc_cnt_d = '0;
                    if (last_iter) begin
                        state_d = ST_DRAIN;
                    end else begin
                        iter_cnt_d = iter_cnt_q + CNT_W'(1);
                    end
                end else begin
                    cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
                end
            end

            ST_DRAIN: begin
                // A result arriving in the final allowed cycle still wins.
                if (dout_pe_v) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Ready flags are registered decodes of the next state; data ready
        // drops as soon as the last burst word has been taken.
        inst_rdy_d = (state_d == ST_LD_INST);
        data_rdy_d = (state_d == ST_LD_DATA) && (data_cnt_d != DATA_ALL);
    end

    pe_scheduler_stream_reg #(
        .WIDTH(INST_WIDTH)
    ) u_inst_fwd (
        .clk       (clk),
        .rst       (rst),
        .in_v_i    (inst_hs),
        .in_data_i (host_inst),
        .out_v_o   (inst_in_v),
        .out_data_o(inst_in)
    );

    pe_scheduler_stream_reg #(
        .WIDTH(2 * DATA_WIDTH)
    ) u_data_fwd (
        .clk       (clk),
        .rst       (rst),
        .in_v_i    (data_hs),
        .in_data_i (host_data),
        .out_v_o   (din_pe_v),
        .out_data_o(din_pe)
    );

    assign host_inst_rdy = inst_rdy_q;
    assign host_data_rdy = data_rdy_q;
    assign alpha_v       = (state_q == ST_RUN) && last_iter;
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign err_timeout   = err_q;

endmodule

// File: tb/tb_pe_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pe_scheduler
// Builds a whole-run schedule up front: per-cycle host/PE stimulus plus the
// expected outputs of every cycle, derived from the job phases (handshake
// positions, iteration windows, drain deadline). A driver replays the
// stimulus and one compare process checks every output on every cycle.
// -----------------------------------------------------------------------------
module tb_pe_scheduler;

    localparam int DW     = 16;
    localparam int IW     = 32;
    localparam int RN     = 8;
    localparam int DM     = 64;
    localparam int DWORDS = 2 * RN;
    localparam int MAXC   = 8000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [5:0]    cfg_n_inst = '0;
    logic [7:0]    cfg_n_iter = '0;
    logic [7:0]    cfg_iter_len = '0;
    logic          host_inst_v = 1'b0;
    logic [IW-1:0] host_inst = '0;
    logic          host_data_v = 1'b0;
    logic [2*DW-1:0] host_data = '0;
    logic          dout_pe_v = 1'b0;

    logic            host_inst_rdy, host_data_rdy;
    logic            inst_in_v, din_pe_v, alpha_v, busy, done, err_timeout;
    logic [IW-1:0]   inst_in;
    logic [2*DW-1:0] din_pe;

    pe_scheduler #(
        .DATA_WIDTH(DW), .INST_WIDTH(IW), .REG_NUM(RN), .DRAIN_MAX(DM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_n_inst   (cfg_n_inst),
        .cfg_n_iter   (cfg_n_iter),
        .cfg_iter_len (cfg_iter_len),
        .host_inst_v  (host_inst_v),
        .host_inst    (host_inst),
        .host_inst_rdy(host_inst_rdy),
        .host_data_v  (host_data_v),
        .host_data    (host_data),
        .host_data_rdy(host_data_rdy),
        .inst_in_v    (inst_in_v),
        .inst_in      (inst_in),
        .din_pe_v     (din_pe_v),
        .din_pe       (din_pe),
        .alpha_v      (alpha_v),
        .dout_pe_v    (dout_pe_v),
        .busy         (busy),
        .done         (done),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    // Per-cycle stimulus.
    bit              d_rst[MAXC], d_start[MAXC], d_iv[MAXC], d_dv[MAXC], d_dout[MAXC];
    logic [5:0]      d_ni[MAXC];
    logic [7:0]      d_nit[MAXC], d_len[MAXC];
    logic [IW-1:0]   d_i[MAXC];
    logic [2*DW-1:0] d_d[MAXC];

    // Per-cycle expectations.
    bit              e_busy[MAXC], e_irdy[MAXC], e_drdy[MAXC], e_iv[MAXC], e_dv[MAXC];
    bit              e_alpha[MAXC], e_done[MAXC], e_err[MAXC], err_set[MAXC], err_clr[MAXC];
    logic [IW-1:0]   e_i[MAXC];
    logic [2*DW-1:0] e_d[MAXC];

    int n_cyc;
    int cur = -1;
    int n_checks = 0;
    int n_fail = 0;
    bit plan_ready = 1'b0;
    int alpha_start;
    int f_j1, s_j2, f_j2, s_j3, f_j3, s_j4, f_j4, s_j5, f_j5;

    function automatic bit pick(input int dens, input int idx);
        if (dens < 0) return (idx % 2) == 0;
        return int'($urandom_range(99)) < dens;
    endfunction

    // Lays out one job starting with start high in cycle s; fin is the cycle
    // in which done must be seen (the job is back in IDLE).
    task automatic plan_job(input int s, input int ni, input int nit, input int len,
                            input int dens, input int dout_off, output int fin);
        int k, cnt, ph, eff, r, dd;
        bit v;
        d_start[s] = 1'b1;
        d_ni[s]    = 6'(ni);
        d_nit[s]   = 8'(nit);
        d_len[s]   = 8'(len);
        err_clr[s+1] = 1'b1;
        k = s + 1;
        cnt = 0; ph = k;
        while (cnt < ni) begin
            v = pick(dens, k - ph);
            e_busy[k] = 1'b1; e_irdy[k] = 1'b1; d_iv[k] = v;
            if (v) begin
                d_i[k] = $urandom;
                e_iv[k+1] = 1'b1; e_i[k+1] = d_i[k];
                cnt++;
            end
            k++;
        end
        cnt = 0; ph = k;
        while (cnt < DWORDS) begin
            v = pick(dens, k - ph);
            e_busy[k] = 1'b1; e_drdy[k] = 1'b1; d_dv[k] = v;
            if (v) begin
                d_d[k] = $urandom;
                e_dv[k+1] = 1'b1; e_d[k+1] = d_d[k];
                cnt++;
            end
            k++;
        end
        if (nit == 0) begin
            fin = k;
        end else begin
            e_busy[k] = 1'b1;
            r = k + 1;
            eff = (len == 0) ? 1 : len;
            alpha_start = r + (nit - 1) * eff;
            for (int c = 0; c < nit * eff; c++) begin
                e_busy[r+c]  = 1'b1;
                e_alpha[r+c] = (r + c >= alpha_start);
            end
            dd = r + nit * eff;
            if (dout_off >= 0 && dout_off < DM) begin
                for (int c = 0; c <= dout_off; c++) begin
                    e_busy[dd+c] = 1'b1;
                    d_dout[dd+c] = (c == dout_off);
                end
                fin = dd + dout_off + 1;
            end else begin
                for (int c = 0; c < DM; c++) begin
                    e_busy[dd+c] = 1'b1;
                    d_dout[dd+c] = 1'b0;
                end
                fin = dd + DM;
                err_set[fin] = 1'b1;
            end
        end
        e_done[fin] = 1'b1;
    endtask

    // Reset asserted in cycle 'at' kills the job: from then on nothing.
    task automatic abort_job(input int at, input int fin_in, output int fin);
        for (int c = at; c <= fin_in + 1; c++) begin
            e_busy[c] = 1'b0; e_irdy[c] = 1'b0; e_drdy[c] = 1'b0;
            e_iv[c] = 1'b0; e_dv[c] = 1'b0; e_alpha[c] = 1'b0;
            e_done[c] = 1'b0; err_set[c] = 1'b0;
        end
        d_rst[at] = 1'b1;
        d_rst[at+1] = 1'b1;
        fin = at + 2;
    endtask

    task automatic check(input string nm, input int k, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, k, act, exp);
        end
    endtask

    // Planner and driver.
    initial begin
        int f, s, tmp, ni, nit, len, dens, doff;
        bit e;
        for (int k = 0; k < MAXC; k++) begin
            d_iv[k] = 1'($urandom); d_i[k] = $urandom;
            d_dv[k] = 1'($urandom); d_d[k] = $urandom;
            d_dout[k] = 1'($urandom);
            d_ni[k] = 6'($urandom); d_nit[k] = 8'($urandom); d_len[k] = 8'($urandom);
        end
        d_rst[0] = 1'b1; d_rst[1] = 1'b1; d_rst[2] = 1'b1;

        plan_job(5, 4, 3, 5, 100, 2, f_j1);
        s_j2 = f_j1 + 1;
        plan_job(s_j2, 0, 1, 0, 100, 0, f_j2);
        s_j3 = f_j2 + 3;
        plan_job(s_j3, 0, 2, 3, -1, 5, f_j3);
        s_j4 = f_j3 + 2;
        plan_job(s_j4, 0, 1, 1, 100, -1, f_j4);
        s_j5 = f_j4 + 2;
        plan_job(s_j5, 3, 2, 2, 70, DM - 1, f_j5);
        // Reset while alpha_v is high.
        s = f_j5 + 1;
        plan_job(s, 2, 2, 4, 100, 3, tmp);
        abort_job(alpha_start + 2, tmp, f);
        s = f + 1;
        plan_job(s, 5, 3, 2, 80, 4, f);
        // Starts while busy and in the done cycle must be ignored.
        s = f + 1;
        plan_job(s, 3, 1, 3, 100, 1, f);
        d_start[s+2] = 1'b1; d_start[s+9] = 1'b1; d_start[f-1] = 1'b1; d_start[f] = 1'b1;
        s = f + 1;
        plan_job(s, 2, 2, 2, 100, 0, f);
        for (int j = 0; j < 14; j++) begin
            if (f > MAXC - 400) break;
            s = f + 1 + int'($urandom_range(3));
            ni = int'($urandom_range(8));
            nit = int'($urandom_range(4));
            len = int'($urandom_range(5));
            dens = int'($urandom_range(40, 100));
            doff = ($urandom_range(5) == 0) ? -1 : int'($urandom_range(20));
            plan_job(s, ni, nit, len, dens, doff, f);
        end
        n_cyc = f + 10;
        e = 1'b0;
        for (int k = 0; k < n_cyc; k++) begin
            if (d_rst[k]) e = 1'b0;
            else if (err_clr[k]) e = 1'b0;
            if (err_set[k]) e = 1'b1;
            e_err[k] = e;
        end
        plan_ready = 1'b1;

        for (int k = 0; k < n_cyc; k++) begin
            @(posedge clk);
            #1;
            rst          = d_rst[k];
            start        = d_start[k];
            cfg_n_inst   = d_ni[k];
            cfg_n_iter   = d_nit[k];
            cfg_iter_len = d_len[k];
            host_inst_v  = d_iv[k];
            host_inst    = d_i[k];
            host_data_v  = d_dv[k];
            host_data    = d_d[k];
            dout_pe_v    = d_dout[k];
            cur          = k;
        end
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Compare process: pins the schedule with hand-computed values, then
    // checks the DUT every cycle.
    initial begin
        int c, first;
        wait (plan_ready);
        // Job 1: start in cycle 5, 4 instr, 3 x 5 cycles, result 2 cycles into drain.
        c = 0; first = -1;
        for (int k = 0; k <= f_j1; k++) begin
            c += int'(e_alpha[k]);
            if (e_alpha[k] && first < 0) first = k;
        end
        check("pin_j1_alpha_len", -1, c, 5);
        check("pin_j1_alpha_first", -1, first, 37);
        c = 0;
        for (int k = 0; k <= f_j1; k++) c += int'(e_iv[k]);
        check("pin_j1_inst_pulses", -1, c, 4);
        c = 0;
        for (int k = 0; k <= f_j1; k++) c += int'(e_dv[k]);
        check("pin_j1_data_pulses", -1, c, 16);
        check("pin_j1_last_din", -1, {e_dv[26], e_dv[27]}, 2'b10);
        check("pin_j1_done", -1, {e_busy[44], e_done[45], e_busy[45], e_err[45]}, 4'b1100);
        // Job 2: no program, one iteration of length 0.
        check("pin_j2_rdy", -1, {e_irdy[s_j2+1], e_drdy[s_j2+1]}, 2'b01);
        check("pin_j2_alpha", -1, {e_dv[s_j2+17], e_alpha[s_j2+17], e_alpha[s_j2+18], e_alpha[s_j2+19]}, 4'b1010);
        // Job 3: host data valid alternating.
        check("pin_j3_rdy_fall", -1, {e_drdy[s_j3+31], e_drdy[s_j3+32]}, 2'b10);
        c = 0;
        for (int k = s_j3; k <= f_j3; k++) c += int'(e_dv[k]);
        check("pin_j3_data_pulses", -1, c, 16);
        // Job 4: timeout 64 cycles into drain; job 5 clears it, result on the last drain cycle.
        check("pin_j4_timeout", -1, {e_done[s_j4+83], e_err[s_j4+83], e_done[s_j4+82]}, 3'b110);
        check("pin_j5_err_clear", -1, {e_err[s_j5], e_err[s_j5+1], e_err[f_j5]}, 3'b100);

        forever begin
            @(negedge clk);
            if (cur >= 0) begin
                check("busy", cur, busy, e_busy[cur]);
                check("host_inst_rdy", cur, host_inst_rdy, e_irdy[cur]);
                check("host_data_rdy", cur, host_data_rdy, e_drdy[cur]);
                check("inst_in_v", cur, inst_in_v, e_iv[cur]);
                check("din_pe_v", cur, din_pe_v, e_dv[cur]);
                check("alpha_v", cur, alpha_v, e_alpha[cur]);
                check("done", cur, done, e_done[cur]);
                check("err_timeout", cur, err_timeout, e_err[cur]);
                if (e_iv[cur]) check("inst_in", cur, inst_in, e_i[cur]);
                if (e_dv[cur]) check("din_pe", cur, din_pe, e_d[cur]);
                if (d_rst[cur]) begin
                    check("inst_in_rst", cur, inst_in, '0);
                    check("din_pe_rst", cur, din_pe, '0);
                end
            end
        end
    end

endmodule

// File: doc/pe_scheduler.md
# pe_scheduler

Sequencer that drives one `pe` through a complete job.
- Accepts a program and an operand burst from the host over valid/ready streams.
- Replays them onto the PE's `inst_in_v/inst_in` and `din_pe_v/din_pe` ports.
- Times the iteration loop and raises `alpha_v` for the final iteration.
- Waits for `dout_pe_v` and reports completion.

It sits between the array-level host/DMA logic and each PE instance.

## Interface
Parameters:
- `DATA_WIDTH`, 16, real/imag width; complex word = 2*DATA_WIDTH
- `INST_WIDTH`, 32, instruction width
- `REG_NUM`, 8, data-memory depth; operand burst = 2*REG_NUM words
- `DRAIN_MAX`, 64, max cycles to wait for `dout_pe_v` after the last iteration

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: job request; sampled only in IDLE
- `cfg_n_inst` in 6: instructions to load; 0 = keep the resident program
- `cfg_n_iter` in 8: iteration count
- `cfg_iter_len` in 8: cycles per iteration; 0 treated as 1
- `host_inst_v` / `host_inst` in 1 / INST_WIDTH; `host_inst_rdy` out 1
- `host_data_v` / `host_data` in 1 / 2*DATA_WIDTH; `host_data_rdy` out 1
- `inst_in_v` / `inst_in` out 1 / INST_WIDTH: to PE
- `din_pe_v` / `din_pe` out 1 / 2*DATA_WIDTH: to PE
- `alpha_v` out 1: to PE, high for the whole final iteration
- `dout_pe_v` in 1: from PE
- `busy` out 1; `done` out 1 (one-cycle pulse); `err_timeout` out 1 (sticky until next accepted start)

## Operation
FSM states: IDLE → LD_INST → LD_DATA → RUN → DRAIN → IDLE.
- **IDLE**: `start` latches all `cfg_*` into shadow registers and clears `err_timeout`. Next state is LD_INST if n_inst≠0, else LD_DATA.
- **LD_INST**: `host_inst_rdy`=1. Each handshake (v&rdy):
  - forwards the word to `inst_in`, registered;
  - increments inst_cnt.
  - On the handshake where inst_cnt reaches n_inst, go to LD_DATA.
- **LD_DATA**: `host_data_rdy`=1. Each handshake forwards the word to `din_pe`. After 2*REG_NUM handshakes:
  - if n_iter=0, go to IDLE with `done`;
  - otherwise go to RUN.
- **RUN**:
  - cyc_cnt counts 0..iter_len-1. On wrap, iter_cnt increments.
  - `alpha_v`=1 while iter_cnt = n_iter-1.
  - After the last cycle of the last iteration, go to DRAIN.
- **DRAIN**:
  - Wait for `dout_pe_v`, then go to IDLE with `done`.
  - If DRAIN_MAX cycles elapse without it, go to IDLE with `done` and set `err_timeout`.
- `busy`=1 in every state except IDLE.
- Host stalls (v low) are legal in both load states: counters hold and PE valids drop.
- `dout_pe_v` outside DRAIN is ignored.
- `start` while busy is ignored; it is not queued.

## Timing
- Reset values: all outputs 0; data/inst outputs 0; FSM in IDLE; all counters 0.
- Reset mid-job aborts immediately. No `done` is issued and no further PE valids are driven.
- Latency:
  - `start` → first `host_*_rdy` high: 1 cycle.
  - Host handshake → PE valid/data: 1 cycle, registered.
- The ready signals are state-decoded registers. They drop in the cycle after the final handshake, so no extra word is accepted.
- The first RUN cycle is the cycle after the registered `din_pe_v` of the final word.
- `alpha_v` rises on the first cycle of iteration n_iter-1 and falls after exactly iter_len cycles.
- `done` is asserted in the cycle the FSM returns to IDLE. A `start` in that same cycle is not accepted; accept on the next cycle.
- `dout_pe_v` arriving in the same cycle the DRAIN timeout expires counts as success (no error).
- Counter widths:
  - cyc_cnt: 8 bits.
  - iter_cnt: 8 bits. Max n_iter is 255, so no wrap.
  - drain counter: clog2(DRAIN_MAX+1) bits.

## Structure
- State encoding localparams and default widths go in the shared `parameters.vh`, alongside DATA_WIDTH, INST_WIDTH and REG_NUM.
- Single module; no sub-module required.
- An optional `stream_reg` (one-entry valid/data pipeline register) may serve both forwarding paths.

## Test plan
- n_inst=4, n_iter=3, iter_len=5, continuous host valid:
  - 4 `inst_in_v` pulses, then 16 `din_pe_v` pulses;
  - `alpha_v` high for exactly 5 cycles, starting 10 cycles into RUN;
  - `dout_pe_v` 2 cycles later → `done` pulse, `err_timeout`=0.
- n_inst=0, n_iter=1, iter_len=0:
  - LD_INST is skipped;
  - `alpha_v` is high for 1 cycle immediately after the data burst.
- Host data valid toggled 1-0-1-0 during LD_DATA:
  - exactly 16 `din_pe_v` pulses with matching data order;
  - `host_data_rdy` falls right after the 16th handshake.
- `dout_pe_v` never arrives with DRAIN_MAX=64:
  - `done` and `err_timeout` are asserted 64 cycles into DRAIN;
  - the next `start` clears `err_timeout`.
- `rst` asserted during RUN with `alpha_v` high:
  - all outputs are 0 asynchronously, the FSM is in IDLE, and no `done` is issued;
  - a new `start` runs a full job correctly.
- `start` pulsed while busy and in the `done` cycle: both are ignored, and `cfg` changes have no effect on the running job.
